// File: rtl/ysyx_25060166_ifu_if.sv
// Fetch-unit bus bundle: memory request/response, IDU instruction handshake and execute redirect.
// The master modport is the IFU side and the slave modport is the memory/IDU/EXU side.
`ifndef ysyx_25060166_WIDTH
`define ysyx_25060166_WIDTH 32
`endif

interface ysyx_25060166_ifu_if #(
    parameter int WIDTH = `ysyx_25060166_WIDTH
) ();
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_addr;
    logic             resp_valid;
    logic [WIDTH-1:0] resp_data;
    logic             inst_valid;
    logic             inst_ready;
    logic [WIDTH-1:0] inst;
    logic [WIDTH-1:0] inst_pc;
    logic             fetch_fault;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;

    modport master (
        output req_valid, req_addr, inst_valid, inst, inst_pc, fetch_fault,
        input  req_ready, resp_valid, resp_data, inst_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  req_valid, req_addr, inst_valid, inst, inst_pc, fetch_fault,
        output req_ready, resp_valid, resp_data, inst_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ysyx_25060166_ifu.sv
// Instruction fetch unit: one outstanding single-beat fetch, valid/ready hand-off to the IDU.
// Optional misaligned-PC fault reporting is enabled by defining YSYX_25060166_IFU_ALIGN_CHK_EN.
//
// state  | meaning
// IDLE   | just out of reset, latch the first fetch address
// REQ    | request presented to memory, held until accepted
// WAIT   | request accepted, waiting for the response beat
// HOLD   | instruction presented to the IDU, held until consumed
`ifndef ysyx_25060166_WIDTH
`define ysyx_25060166_WIDTH 32
`endif

module ysyx_25060166_ifu #(
    parameter int               WIDTH    = `ysyx_25060166_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h8000_0000)
) (
    input logic                 clk,
    input logic                 rst_n,
    ysyx_25060166_ifu_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] fetch_addr_q, fetch_addr_d;
    logic             drop_q, drop_d;
    logic [WIDTH-1:0] inst_q, inst_d;
    logic [WIDTH-1:0] inst_pc_q, inst_pc_d;
`ifdef YSYX_25060166_IFU_ALIGN_CHK_EN
    logic             fault_q, fault_d;
`endif

    logic             go_req;
    logic [WIDTH-1:0] req_target;
    logic [WIDTH-1:0] pc_inc;

    assign pc_inc = pc_q + WIDTH'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            fetch_addr_q <= RESET_PC;
            drop_q       <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= RESET_PC;
`ifdef YSYX_25060166_IFU_ALIGN_CHK_EN
            fault_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            drop_q       <= drop_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
`ifdef YSYX_25060166_IFU_ALIGN_CHK_EN
            fault_q      <= fault_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        drop_d       = drop_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
`ifdef YSYX_25060166_IFU_ALIGN_CHK_EN
        fault_d      = fault_q;
`endif
        go_req       = 1'b0;
        req_target   = fetch_addr_q;

        case (state_q)
            S_IDLE: begin
                go_req     = 1'b1;
                req_target = bus.redirect_valid ? bus.redirect_pc : pc_q;
                if (bus.redirect_valid) pc_d = bus.redirect_pc;
            end
            S_REQ: begin
                // The in-flight address stays put; only the response gets squashed later.
                if (bus.redirect_valid) begin
                    pc_d   = bus.redirect_pc;
                    drop_d = 1'b1;
                end
                if (bus.req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.redirect_valid) begin
                    pc_d = bus.redirect_pc;
                    if (bus.resp_valid) begin
                        drop_d     = 1'b0;
                        go_req     = 1'b1;
                        req_target = bus.redirect_pc;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (bus.resp_valid) begin
                    if (drop_q) begin
                        drop_d     = 1'b0;
                        go_req     = 1'b1;
                        req_target = pc_q;
                    end else begin
                        inst_d    = bus.resp_data;
                        inst_pc_d = fetch_addr_q;
                        state_d   = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (bus.redirect_valid) begin
                    pc_d       = bus.redirect_pc;
                    go_req     = 1'b1;
                    req_target = bus.redirect_pc;
                end else if (bus.inst_ready) begin
                    pc_d       = pc_inc;
                    go_req     = 1'b1;
                    req_target = pc_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (go_req) begin
            fetch_addr_d = req_target;
            state_d      = S_REQ;
`ifdef YSYX_25060166_IFU_ALIGN_CHK_EN
            // A misaligned target never reaches memory; it is reported to the IDU as a fault.
            fault_d      = 1'b0;
            if (req_target[1:0] != 2'b00) begin
                state_d   = S_HOLD;
                fault_d   = 1'b1;
                inst_d    = '0;
                inst_pc_d = req_target;
            end
`endif
        end
    end

    assign bus.req_valid  = (state_q == S_REQ);
    assign bus.inst_valid = (state_q == S_HOLD);
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
`ifdef YSYX_25060166_IFU_ALIGN_CHK_EN
    assign bus.req_addr    = fetch_addr_q;
    assign bus.fetch_fault = fault_q;
`else
    assign bus.req_addr    = {fetch_addr_q[WIDTH-1:2], 2'b00};
    assign bus.fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_25060166_ifu.sv
// Directed testbench for ysyx_25060166_ifu; inputs change 1 time unit after the rising edge.
module tb_ysyx_25060166_ifu;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ysyx_25060166_ifu_if #(.WIDTH(32)) bus ();

    ysyx_25060166_ifu #(
        .WIDTH   (32),
        .RESET_PC(32'h8000_0000)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (bus.req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %0b want 0", bus.req_valid); end
        checks++; if (bus.req_addr !== 32'h8000_0000) begin errors++; $display("FAIL reset_req_addr: got %h want 80000000", bus.req_addr); end
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %0b want 0", bus.inst_valid); end
        checks++; if (bus.inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h want 00000000", bus.inst); end
        checks++; if (bus.inst_pc !== 32'h8000_0000) begin errors++; $display("FAIL reset_inst_pc: got %h want 80000000", bus.inst_pc); end
        checks++; if (bus.fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %0b want 0", bus.fetch_fault); end
        step();
        checks++; if (bus.req_valid !== 1'b0) begin errors++; $display("FAIL reset_held_req_valid: got %0b want 0", bus.req_valid); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        bit seen;
        seen = 1'b0;
        bus.req_ready  = 1'b1;
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.req_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL first_req_timeout: got no req_valid want req_valid within 8 cycles"); end
        checks++; if (bus.req_addr !== 32'h8000_0000) begin errors++; $display("FAIL first_req_addr: got %h want 80000000", bus.req_addr); end
        step();
        bus.resp_valid = 1'b1;
        bus.resp_data  = 32'h0000_0413;
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL basic_wait_inst_valid: got %0b want 0", bus.inst_valid); end
        step();
        bus.resp_valid = 1'b0;
        checks++; if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL basic_inst_valid: got %0b want 1", bus.inst_valid); end
        checks++; if (bus.inst !== 32'h0000_0413) begin errors++; $display("FAIL basic_inst: got %h want 00000413", bus.inst); end
        checks++; if (bus.inst_pc !== 32'h8000_0000) begin errors++; $display("FAIL basic_inst_pc: got %h want 80000000", bus.inst_pc); end
        checks++; if (bus.fetch_fault !== 1'b0) begin errors++; $display("FAIL basic_fault: got %0b want 0", bus.fetch_fault); end
        bus.req_ready = 1'b0;
        step();
        checks++; if (bus.req_valid !== 1'b1) begin errors++; $display("FAIL basic_next_req_valid: got %0b want 1", bus.req_valid); end
        checks++; if (bus.req_addr !== 32'h8000_0004) begin errors++; $display("FAIL basic_next_req_addr: got %h want 80000004", bus.req_addr); end
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL basic_after_hs_inst_valid: got %0b want 0", bus.inst_valid); end
    endtask

    task automatic test_stall();
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.req_valid !== 1'b1 || bus.req_addr !== 32'h8000_0004) begin errors++; $display("FAIL stall_req cycle %0d: got valid=%0b addr=%h want valid=1 addr=80000004", i, bus.req_valid, bus.req_addr); end
        end
        bus.req_ready = 1'b1;
        step();
        bus.resp_valid = 1'b1;
        bus.resp_data  = 32'h0010_0093;
        step();
        bus.resp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.inst_valid !== 1'b1 || bus.inst !== 32'h0010_0093 || bus.inst_pc !== 32'h8000_0004 || bus.req_valid !== 1'b0) begin
                errors++; $display("FAIL hold_stable cycle %0d: got iv=%0b inst=%h pc=%h rv=%0b want iv=1 inst=00100093 pc=80000004 rv=0", i, bus.inst_valid, bus.inst, bus.inst_pc, bus.req_valid);
            end
            step();
        end
        bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;
        checks++; if (bus.req_valid !== 1'b1 || bus.req_addr !== 32'h8000_0008) begin errors++; $display("FAIL stall_next_req: got valid=%0b addr=%h want valid=1 addr=80000008", bus.req_valid, bus.req_addr); end
    endtask

    task automatic test_redirect_wait();
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0100;
        step();
        bus.redirect_valid = 1'b0;
        bus.resp_valid     = 1'b1;
        bus.resp_data      = 32'hBADB_AD00;
        step();
        bus.resp_valid = 1'b0;
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL redir_wait_dropped: got inst_valid=%0b want 0", bus.inst_valid); end
        checks++; if (bus.req_valid !== 1'b1 || bus.req_addr !== 32'h8000_0100) begin errors++; $display("FAIL redir_wait_req: got valid=%0b addr=%h want valid=1 addr=80000100", bus.req_valid, bus.req_addr); end
        step();
        bus.resp_valid = 1'b1;
        bus.resp_data  = 32'h0000_0513;
        step();
        bus.resp_valid = 1'b0;
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst !== 32'h0000_0513 || bus.inst_pc !== 32'h8000_0100) begin
            errors++; $display("FAIL redir_wait_inst: got iv=%0b inst=%h pc=%h want iv=1 inst=00000513 pc=80000100", bus.inst_valid, bus.inst, bus.inst_pc);
        end
    endtask

    task automatic test_redirect_hold();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0040;
        bus.inst_ready     = 1'b1;
        step();
        bus.redirect_valid = 1'b0;
        bus.inst_ready     = 1'b0;
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL redir_hold_consumed: got inst_valid=%0b want 0", bus.inst_valid); end
        checks++; if (bus.req_valid !== 1'b1 || bus.req_addr !== 32'h8000_0040) begin errors++; $display("FAIL redir_hold_req: got valid=%0b addr=%h want valid=1 addr=80000040", bus.req_valid, bus.req_addr); end
        step();
        bus.resp_valid = 1'b1;
        bus.resp_data  = 32'h00A0_0593;
        step();
        bus.resp_valid = 1'b0;
        checks++; if (bus.inst_pc !== 32'h8000_0040 || bus.inst !== 32'h00A0_0593) begin errors++; $display("FAIL redir_hold_inst: got inst=%h pc=%h want inst=00a00593 pc=80000040", bus.inst, bus.inst_pc); end
        bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;
        checks++; if (bus.req_addr !== 32'h8000_0044) begin errors++; $display("FAIL redir_hold_seq: got %h want 80000044", bus.req_addr); end
    endtask

    task automatic test_redirect_wait_resp();
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0200;
        bus.resp_valid     = 1'b1;
        bus.resp_data      = 32'hDEAD_BEEF;
        step();
        bus.redirect_valid = 1'b0;
        bus.resp_valid     = 1'b0;
        checks++; if (bus.inst_valid !== 1'b0 || bus.req_valid !== 1'b1 || bus.req_addr !== 32'h8000_0200) begin
            errors++; $display("FAIL redir_resp_same: got iv=%0b rv=%0b addr=%h want iv=0 rv=1 addr=80000200", bus.inst_valid, bus.req_valid, bus.req_addr);
        end
        step();
        bus.resp_valid = 1'b1;
        bus.resp_data  = 32'h0000_0013;
        step();
        bus.resp_valid = 1'b0;
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h8000_0200) begin errors++; $display("FAIL redir_resp_no_drop: got iv=%0b pc=%h want iv=1 pc=80000200", bus.inst_valid, bus.inst_pc); end
    endtask

    task automatic test_wrap();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        step();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req_top: got %h want fffffffc", bus.req_addr); end
        step();
        bus.resp_valid = 1'b1;
        bus.resp_data  = 32'h0000_0073;
        step();
        bus.resp_valid = 1'b0;
        checks++; if (bus.inst_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_inst_pc: got %h want fffffffc", bus.inst_pc); end
        bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;
        bus.req_ready  = 1'b0;
        checks++; if (bus.req_valid !== 1'b1 || bus.req_addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap_req_zero: got valid=%0b addr=%h want valid=1 addr=00000000", bus.req_valid, bus.req_addr); end
    endtask

    task automatic test_resp_outside_wait();
        bus.resp_valid = 1'b1;
        bus.resp_data  = 32'h1234_5678;
        step();
        bus.resp_valid = 1'b0;
        checks++; if (bus.req_valid !== 1'b1 || bus.inst_valid !== 1'b0 || bus.req_addr !== 32'h0) begin
            errors++; $display("FAIL resp_in_req: got rv=%0b iv=%0b addr=%h want rv=1 iv=0 addr=00000000", bus.req_valid, bus.inst_valid, bus.req_addr);
        end
        bus.req_ready = 1'b1;
        step();
        bus.resp_valid = 1'b1;
        bus.resp_data  = 32'h0000_0013;
        step();
        bus.resp_valid = 1'b0;
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst !== 32'h0000_0013 || bus.inst_pc !== 32'h0) begin
            errors++; $display("FAIL resp_in_req_after: got iv=%0b inst=%h pc=%h want iv=1 inst=00000013 pc=00000000", bus.inst_valid, bus.inst, bus.inst_pc);
        end
    endtask

    task automatic test_misalign();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0002;
        step();
        bus.redirect_valid = 1'b0;
`ifdef YSYX_25060166_IFU_ALIGN_CHK_EN
        checks++; if (bus.req_valid !== 1'b0 || bus.inst_valid !== 1'b1 || bus.fetch_fault !== 1'b1) begin
            errors++; $display("FAIL misalign_fault: got rv=%0b iv=%0b fault=%0b want rv=0 iv=1 fault=1", bus.req_valid, bus.inst_valid, bus.fetch_fault);
        end
        checks++; if (bus.inst_pc !== 32'h8000_0002 || bus.inst !== 32'h0) begin errors++; $display("FAIL misalign_inst: got inst=%h pc=%h want inst=00000000 pc=80000002", bus.inst, bus.inst_pc); end
        bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;
        checks++; if (bus.inst_valid !== 1'b1 || bus.fetch_fault !== 1'b1 || bus.inst_pc !== 32'h8000_0006) begin
            errors++; $display("FAIL misalign_next: got iv=%0b fault=%0b pc=%h want iv=1 fault=1 pc=80000006", bus.inst_valid, bus.fetch_fault, bus.inst_pc);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0000;
        step();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.req_valid !== 1'b1 || bus.req_addr !== 32'h8000_0000) begin errors++; $display("FAIL misalign_recover: got valid=%0b addr=%h want valid=1 addr=80000000", bus.req_valid, bus.req_addr); end
`else
        checks++; if (bus.req_valid !== 1'b1 || bus.req_addr !== 32'h8000_0000) begin errors++; $display("FAIL misalign_req: got valid=%0b addr=%h want valid=1 addr=80000000", bus.req_valid, bus.req_addr); end
        checks++; if (bus.fetch_fault !== 1'b0 || bus.inst_valid !== 1'b0) begin errors++; $display("FAIL misalign_nofault: got fault=%0b iv=%0b want fault=0 iv=0", bus.fetch_fault, bus.inst_valid); end
`endif
    endtask

    task automatic test_reset_midfetch();
        bus.req_ready = 1'b1;
        step();
        rst_n = 1'b0;
        #2;
        checks++; if (bus.req_valid !== 1'b0 || bus.inst_valid !== 1'b0 || bus.req_addr !== 32'h8000_0000 || bus.inst_pc !== 32'h8000_0000 || bus.inst !== 32'h0) begin
            errors++; $display("FAIL midfetch_reset: got rv=%0b iv=%0b addr=%h inst=%h pc=%h want rv=0 iv=0 addr=80000000 inst=00000000 pc=80000000", bus.req_valid, bus.inst_valid, bus.req_addr, bus.inst, bus.inst_pc);
        end
        step();
        rst_n          = 1'b1;
        bus.resp_valid = 1'b1;
        bus.resp_data  = 32'hCAFE_F00D;
        step();
        bus.resp_valid = 1'b0;
        checks++; if (bus.inst_valid !== 1'b0 || bus.req_valid !== 1'b1 || bus.req_addr !== 32'h8000_0000) begin
            errors++; $display("FAIL midfetch_late_resp: got iv=%0b rv=%0b addr=%h want iv=0 rv=1 addr=80000000", bus.inst_valid, bus.req_valid, bus.req_addr);
        end
    endtask

    initial begin
        clk                = 1'b0;
        rst_n              = 1'b0;
        checks             = 0;
        errors             = 0;
        bus.req_ready      = 1'b0;
        bus.resp_valid     = 1'b0;
        bus.resp_data      = '0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;

        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_redirect_wait_resp();
        test_wrap();
        test_resp_outside_wait();
        test_misalign();
        test_reset_midfetch();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
